// File: rtl/ysyx_22050039_lsu.sv
// ============================================================================
// Module      : ysyx_22050039_lsu
// Description : Load/store unit. One aligned 64-bit bus transaction per
//               memory instruction; passthrough for non-memory results.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_22050039_lsu #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_mem,
  input  logic [3:0]      in_op,
  input  logic [XLEN-1:0] in_addr,
  input  logic [XLEN-1:0] in_wdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_data,
  output logic            out_misalign,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_addr,
  output logic            mem_wen,
  output logic [XLEN-1:0] mem_wdata,
  output logic [7:0]      mem_wmask,
  input  logic            mem_resp_valid,
  input  logic [XLEN-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [3:0]      r_op;
  logic [2:0]      r_off;
  logic            w_misalign;
  logic [7:0]      w_mask;
  logic [XLEN-1:0] w_shifted;
  logic [XLEN-1:0] w_load;

  assign in_ready      = (r_state == IDLE);
  assign out_valid     = (r_state == DONE);
  assign mem_req_valid = (r_state == REQ);

  always_comb begin
    w_misalign = 1'b0;
    w_mask     = 8'hFF;
    case (in_op[1:0])
      2'd0: begin
        w_mask = 8'h01 << in_addr[2:0];
      end
      2'd1: begin
        w_misalign = in_addr[0];
        w_mask     = 8'h03 << in_addr[2:0];
      end
      2'd2: begin
        w_misalign = |in_addr[1:0];
        w_mask     = 8'h0F << in_addr[2:0];
      end
      default: begin
        w_misalign = |in_addr[2:0];
        w_mask     = 8'hFF;
      end
    endcase
  end

  // Bring the addressed lane down to bit 0, then truncate and extend by size.
  assign w_shifted = mem_rdata >> {r_off, 3'b000};

  always_comb begin
    w_load = w_shifted;
    case (r_op[1:0])
      2'd0: w_load = r_op[2] ? {{(XLEN-8){1'b0}}, w_shifted[7:0]}
                             : {{(XLEN-8){w_shifted[7]}}, w_shifted[7:0]};
      2'd1: w_load = r_op[2] ? {{(XLEN-16){1'b0}}, w_shifted[15:0]}
                             : {{(XLEN-16){w_shifted[15]}}, w_shifted[15:0]};
      2'd2: w_load = r_op[2] ? {{(XLEN-32){1'b0}}, w_shifted[31:0]}
                             : {{(XLEN-32){w_shifted[31]}}, w_shifted[31:0]};
      default: w_load = w_shifted;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (in_valid) w_state_nxt = (in_mem && !w_misalign) ? REQ : DONE;
      REQ:  if (mem_req_ready) w_state_nxt = WAIT;
      WAIT: if (mem_resp_valid) w_state_nxt = DONE;
      DONE: if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op         <= '0;
      r_off        <= '0;
      out_data     <= '0;
      out_misalign <= 1'b0;
      mem_addr     <= '0;
      mem_wen      <= 1'b0;
      mem_wdata    <= '0;
      mem_wmask    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_op         <= in_op;
            r_off        <= in_addr[2:0];
            out_misalign <= in_mem & w_misalign;
            out_data     <= in_mem ? '0 : in_addr;
            mem_addr     <= {in_addr[XLEN-1:3], 3'b000};
            mem_wen      <= in_op[3];
            mem_wdata    <= in_wdata << {in_addr[2:0], 3'b000};
            mem_wmask    <= in_op[3] ? w_mask : 8'h00;
          end
        end
        WAIT: begin
          if (mem_resp_valid) out_data <= r_op[3] ? '0 : w_load;
        end
        DONE: begin
          if (out_ready) out_misalign <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/ysyx_22050039_lsu.md
# ysyx_22050039_lsu

Load/store unit directly downstream of the execute stage. Takes the execute result as an effective address (or as a plain result for non-memory instructions) together with store data and a memory-op code. Performs one 64-bit-bus data-memory transaction through a request/response handshake, aligns and extends load data, and hands a single result to write-back. Multi-cycle FSM; the core stalls on `in_ready`/`out_valid`.

## Interface
- `XLEN`, 64, datapath and address width; the bus is 8 bytes wide.
- `clk` in 1, the single clock.
- `rst` in 1, synchronous, active-high reset.
- `in_valid` in 1, execute stage presents an instruction.
- `in_ready` out 1, LSU can accept; high only in IDLE.
- `in_mem` in 1, 1 means memory instruction, 0 means pass `in_addr` through as the result.
- `in_op` in 4, [3]=store, [2]=unsigned load, [1:0]=size (0 B, 1 H, 2 W, 3 D).
- `in_addr` in XLEN, execute result or effective address.
- `in_wdata` in XLEN, store data, right-aligned.
- `out_valid` out 1, result available to write-back.
- `out_ready` in 1, write-back accepts.
- `out_data` out XLEN, load data, passthrough value, or 0 for stores and errors.
- `out_misalign` out 1, the access was misaligned and no bus request was issued.
- `mem_req_valid` out 1, bus request.
- `mem_req_ready` in 1, bus accepts the request.
- `mem_addr` out XLEN, `{in_addr[XLEN-1:3], 3'b0}`.
- `mem_wen` out 1, the request is a store.
- `mem_wdata` out XLEN, store data shifted to its byte lane.
- `mem_wmask` out 8, byte enables; 0 for loads.
- `mem_resp_valid` in 1, response or store acknowledge; one pulse per request.
- `mem_rdata` in XLEN, load data; valid with `mem_resp_valid`.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid`, latch op, addr, and wdata.
  - If `in_mem`=0: `out_data`<=`in_addr`, go to DONE.
  - Else if misaligned: `out_misalign`<=1, `out_data`<=0, go to DONE.
  - Else go to REQ.
- **Misalignment rules**
  - H with addr[0]≠0.
  - W with addr[1:0]≠0.
  - D with addr[2:0]≠0.
  - B is never misaligned.
- **REQ**
  - `mem_req_valid`=1.
  - `mem_addr`, `mem_wen`, `mem_wdata`, and `mem_wmask` driven from latched registers, stable until `mem_req_ready`.
  - On `mem_req_ready`, go to WAIT.
- **WAIT**
  - On `mem_resp_valid`:
    - Load: `out_data` <= extend(`mem_rdata` >> 8·addr[2:0]) truncated to size, signed unless op[2]; D ignores op[2].
    - Store: `out_data`<=0.
  - Then go to DONE.
- **DONE**
  - `out_valid`=1.
  - On `out_ready`, clear `out_misalign` and go to IDLE.
- **Write mask**
  - B: 8'h01<<a.
  - H: 8'h03<<a.
  - W: 8'h0F<<a.
  - D: 8'hFF.
  - Here a=addr[2:0].
- **Write data**: `in_wdata`<<8·a; bits above the size are don't-care but masked off.
- **Ignored inputs**
  - `mem_resp_valid` outside WAIT.
  - `in_valid` outside IDLE.
  - `mem_req_ready` outside REQ.

## Timing
- **Reset values**: state=IDLE; `out_valid`, `out_data`, `out_misalign`, `mem_req_valid`, `mem_wen`, `mem_wmask`, `mem_addr`, and `mem_wdata` all 0.
- **Outputs**: all registered or decoded from state only; no combinational path from any input to any output.
- **Latency**, counted from the accept edge at cycle 0:
  - Passthrough or misaligned: `out_valid` at cycle 1.
  - Memory access: `mem_req_valid` from cycle 1. With ready in cycle 1 and response in cycle 2, `out_valid` is at cycle 3. Each cycle of ready or response delay adds one cycle.
- **Throughput**: at most one instruction per 2 cycles, since IDLE and DONE are separate.
- **`out_valid`**: held with stable `out_data` until `out_ready` is sampled high.
- **Reset mid-operation**
  - Any state returns to IDLE next edge.
  - `mem_req_valid` drops immediately.
  - A late `mem_resp_valid` is ignored.
  - The bus owner must tolerate an abandoned request.
- **`mem_req_ready` and `mem_resp_valid` high in the same REQ cycle**: the response is ignored. The bus must not respond before the accept cycle.

## Test plan
- **Passthrough**: `in_mem`=0, addr=0x8000_0010 -> `out_valid` next cycle, `out_data`=0x8000_0010, no `mem_req_valid`.
- **Signed byte load (LB)**: addr=0x8000_0003, `mem_rdata`=0x1122_3344_8566_7788 -> `mem_addr`=0x8000_0000, `mem_wmask`=0, `out_data`=0xFFFF_FFFF_FFFF_FF85. With op[2]=1 (LBU), `out_data`=0x85.
- **Word store (SW)**: addr=0x8000_0004, wdata=0xDEAD_BEEF -> `mem_wen`=1, `mem_wmask`=8'hF0, `mem_wdata`[63:32]=0xDEAD_BEEF; `out_data`=0 after the ack.
- **Misaligned access**: LH at 0x8000_0001 -> `out_misalign`=1 at cycle 1, `mem_req_valid` never asserted. SD at 0x...04 behaves the same.
- **Backpressure**:
  - `mem_req_ready` low for 3 cycles: request fields are stable throughout.
  - Response delayed 2 cycles.
  - `out_ready` low for 2 cycles: `out_data` is held.
  - Total latency equals 3 plus the stall cycles.
- **Reset during WAIT**: next cycle state=IDLE and all outputs 0. A stray `mem_resp_valid` afterwards produces no `out_valid`, and a new LD then completes normally.
